// File: rtl/olive_alarm_pkg.sv
// Shared definitions for the alarm scheduler: bus widths, register address
// map and helpers that locate the per-channel deadline registers.
package olive_alarm_pkg;

   localparam int TICK_W = 32;
   localparam int ADDR_W = 4;
   localparam int DATA_W = 16;

   localparam logic [ADDR_W-1:0] ADDR_PENDING = 4'd0;
   localparam logic [ADDR_W-1:0] ADDR_IRQEN   = 4'd1;
   localparam logic [ADDR_W-1:0] ADDR_ARMED   = 4'd2;
   localparam logic [ADDR_W-1:0] ADDR_TICK_LO = 4'd3;
   localparam logic [ADDR_W-1:0] ADDR_TICK_HI = 4'd4;
   localparam logic [ADDR_W-1:0] ADDR_DL_BASE = 4'd6;

   // Each channel owns a lo/hi word pair starting at ADDR_DL_BASE.
   function automatic logic [ADDR_W-1:0] dl_lo_addr(input int c);
      return ADDR_W'(int'(ADDR_DL_BASE) + 2 * c);
   endfunction

   function automatic logic [ADDR_W-1:0] dl_hi_addr(input int c);
      return ADDR_W'(int'(ADDR_DL_BASE) + 2 * c + 1);
   endfunction

endpackage

// File: rtl/olive_alarm_tick.sv
// Free-running time base: a down-counting prescaler that advances a 32-bit
// tick counter once every PRESCALE clocks. The tick wraps modulo 2^32.
//   clk        system clock
//   reset_n    synchronous active-low reset
//   tick_q     current tick value
//   tick_pulse high in the cycle whose closing edge increments tick_q
module olive_alarm_tick
   import olive_alarm_pkg::*;
#(
   parameter int PRESCALE = 50
) (
   input  logic              clk,
   input  logic              reset_n,
   output logic [TICK_W-1:0] tick_q,
   output logic              tick_pulse
);

   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PS_W-1:0]   presc_reg;
   logic [TICK_W-1:0] tick_reg;

   assign tick_pulse = (presc_reg == '0);
   assign tick_q     = tick_reg;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         presc_reg <= PS_W'(PRESCALE - 1);
         tick_reg  <= '0;
      end else if (tick_pulse) begin
         presc_reg <= PS_W'(PRESCALE - 1);
         tick_reg  <= tick_reg + TICK_W'(1);
      end else begin
         presc_reg <= presc_reg - PS_W'(1);
      end
   end

endmodule

// File: rtl/olive_std_core_alarm_sched.sv
// One-shot alarm scheduler: N_CH software alarms share one tick counter and
// one wrap-safe comparator, visited round-robin one channel per clock.
// Expired channels latch pending bits that drive a single level interrupt.
//   clk, reset_n     clock and synchronous active-low reset
//   address          word address of the 16-bit Avalon-MM slave
//   chipselect       slave select
//   write_n, read_n  active-low strobes (reads only matter for side effects)
//   writedata        write data
//   readdata         registered read data, one cycle after address
//   irq              |(pending & irq_enable)
module olive_std_core_alarm_sched
   import olive_alarm_pkg::*;
#(
   parameter int N_CH     = 4,
   parameter int PRESCALE = 50
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic              read_n,
   input  logic [DATA_W-1:0] writedata,
   output logic [DATA_W-1:0] readdata,
   output logic              irq
);

   localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic              wr_en;
   logic              rd_en;
   logic [TICK_W-1:0] tick_q;
   logic              tick_step_unused;
   logic [N_CH-1:0]   pending_vec;
   logic [N_CH-1:0]   armed_vec;
   logic [N_CH-1:0]   irq_en_reg;
   logic [TICK_W-1:0] deadline_arr [N_CH];
   logic [DATA_W-1:0] stage_lo_arr [N_CH];
   logic [IDX_W-1:0]  idx_reg;
   logic [DATA_W-1:0] tick_hi_reg;
   logic [DATA_W-1:0] readdata_reg;
   logic [DATA_W-1:0] rd_mux;
   logic [TICK_W-1:0] scan_diff;
   logic              scan_expired;

   assign wr_en = chipselect & ~write_n;
   assign rd_en = chipselect & ~read_n;

   // The scanner samples the tick every cycle, so the per-tick strobe has
   // no consumer here.
   olive_alarm_tick #(
      .PRESCALE (PRESCALE)
   ) u_tick (
      .clk        (clk),
      .reset_n    (reset_n),
      .tick_q     (tick_q),
      .tick_pulse (tick_step_unused)
   );

   // Wrap-safe test: the deadline has been reached when the modular
   // distance from it to now is non-negative as a signed 32-bit value.
   assign scan_diff    = tick_q - deadline_arr[idx_reg];
   assign scan_expired = armed_vec[idx_reg] & ~scan_diff[TICK_W-1];

   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_ch
         logic              lo_wr;
         logic              hi_wr;
         logic              disarm_wr;
         logic              clear_wr;
         logic              scan_hit;
         logic              armed_reg;
         logic              pending_reg;
         logic [TICK_W-1:0] deadline_reg;
         logic [DATA_W-1:0] stage_lo_reg;

         assign lo_wr     = wr_en && (address == dl_lo_addr(gi));
         assign hi_wr     = wr_en && (address == dl_hi_addr(gi));
         assign disarm_wr = wr_en && (address == ADDR_ARMED) && writedata[gi];
         assign clear_wr  = wr_en && (address == ADDR_PENDING) && writedata[gi];
         assign scan_hit  = scan_expired && (idx_reg == IDX_W'(gi));

         // Priority: re-arm beats a stale expiry, disarm beats expiry,
         // expiry beats a pending clear.
         always_ff @(posedge clk) begin
            if (!reset_n) begin
               armed_reg    <= 1'b0;
               pending_reg  <= 1'b0;
               deadline_reg <= '0;
               stage_lo_reg <= '0;
            end else begin
               if (lo_wr) begin
                  stage_lo_reg <= writedata;
               end
               if (hi_wr) begin
                  deadline_reg <= {writedata, stage_lo_reg};
                  armed_reg    <= 1'b1;
                  pending_reg  <= 1'b0;
               end else if (disarm_wr) begin
                  armed_reg <= 1'b0;
               end else if (scan_hit) begin
                  armed_reg   <= 1'b0;
                  pending_reg <= 1'b1;
               end else if (clear_wr) begin
                  pending_reg <= 1'b0;
               end
            end
         end

         assign armed_vec[gi]    = armed_reg;
         assign pending_vec[gi]  = pending_reg;
         assign deadline_arr[gi] = deadline_reg;
         assign stage_lo_arr[gi] = stage_lo_reg;
      end
   endgenerate

   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_PENDING: rd_mux[N_CH-1:0] = pending_vec;
         ADDR_IRQEN:   rd_mux[N_CH-1:0] = irq_en_reg;
         ADDR_ARMED:   rd_mux[N_CH-1:0] = armed_vec;
         ADDR_TICK_LO: rd_mux = tick_q[DATA_W-1:0];
         ADDR_TICK_HI: rd_mux = tick_hi_reg;
         default:      rd_mux = '0;
      endcase
      for (int c = 0; c < N_CH; c++) begin
         if (address == dl_lo_addr(c)) begin
            rd_mux = stage_lo_arr[c];
         end
         if (address == dl_hi_addr(c)) begin
            rd_mux = deadline_arr[c][TICK_W-1:DATA_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         irq_en_reg   <= '0;
         idx_reg      <= '0;
         tick_hi_reg  <= '0;
         readdata_reg <= '0;
      end else begin
         readdata_reg <= rd_mux;
         if (wr_en && (address == ADDR_IRQEN)) begin
            irq_en_reg <= writedata[N_CH-1:0];
         end
         // Latch the upper half together with the low-half read so a
         // following shadow read gives a coherent 32-bit value.
         if (rd_en && (address == ADDR_TICK_LO)) begin
            tick_hi_reg <= tick_q[TICK_W-1:DATA_W];
         end
         if (idx_reg == IDX_W'(N_CH - 1)) begin
            idx_reg <= '0;
         end else begin
            idx_reg <= idx_reg + IDX_W'(1);
         end
      end
   end

   assign readdata = readdata_reg;
   assign irq      = |(pending_vec & irq_en_reg);

endmodule

// File: tb/tb_olive_std_core_alarm_sched.sv
module tb_olive_std_core_alarm_sched;

   localparam int N_CH    = 4;
   localparam int PS_SLOW = 5;

   logic        clk        = 1'b0;
   logic        reset_n    = 1'b0;
   logic [3:0]  address    = 4'd0;
   logic        chipselect = 1'b0;
   logic        write_n    = 1'b1;
   logic        read_n     = 1'b1;
   logic [15:0] writedata  = 16'd0;
   logic [15:0] readdata;
   logic [15:0] readdata_p;
   logic        irq;
   logic        irq_p;

   always #5 clk = ~clk;

   olive_std_core_alarm_sched #(.N_CH(N_CH), .PRESCALE(1)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .read_n(read_n), .writedata(writedata),
      .readdata(readdata), .irq(irq)
   );

   olive_std_core_alarm_sched #(.N_CH(N_CH), .PRESCALE(PS_SLOW)) dut_p (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .read_n(read_n), .writedata(writedata),
      .readdata(readdata_p), .irq(irq_p)
   );

   // Clock edges seen with reset released; equals the tick at PRESCALE=1.
   logic [31:0] cyc = 32'd0;
   always @(posedge clk) begin
      if (!reset_n) cyc <= 32'd0;
      else          cyc <= cyc + 32'd1;
   end

   // ---------------- reference model ----------------
   logic [N_CH-1:0] m_pend, m_arm, m_irqen;
   logic [31:0]     m_dl    [N_CH];
   logic [15:0]     m_stage [N_CH];
   logic [15:0]     m_shadow;

   function automatic void m_reset();
      m_pend = '0; m_arm = '0; m_irqen = '0; m_shadow = 16'd0;
      for (int c = 0; c < N_CH; c++) begin
         m_dl[c] = 32'd0; m_stage[c] = 16'd0;
      end
   endfunction

   function automatic logic [15:0] m_read(input logic [3:0] a);
      logic [15:0] r;
      r = 16'd0;
      if (a == 4'd0) r = 16'(m_pend);
      if (a == 4'd1) r = 16'(m_irqen);
      if (a == 4'd2) r = 16'(m_arm);
      if (a == 4'd3) r = cyc[15:0];
      if (a == 4'd4) r = m_shadow;
      for (int c = 0; c < N_CH; c++) begin
         if (int'(a) == 6 + 2 * c) r = m_stage[c];
         if (int'(a) == 7 + 2 * c) r = m_dl[c][31:16];
      end
      return r;
   endfunction

   function automatic void m_write(input logic [3:0] a, input logic [15:0] d);
      if (a == 4'd0) m_pend  = m_pend & ~d[N_CH-1:0];
      if (a == 4'd1) m_irqen = d[N_CH-1:0];
      if (a == 4'd2) m_arm   = m_arm & ~d[N_CH-1:0];
      for (int c = 0; c < N_CH; c++) begin
         if (int'(a) == 6 + 2 * c) m_stage[c] = d;
         if (int'(a) == 7 + 2 * c) begin
            m_dl[c] = {d, m_stage[c]}; m_arm[c] = 1'b1; m_pend[c] = 1'b0;
         end
      end
   endfunction

   // Any armed alarm whose deadline is not in the future (signed modular
   // distance) has fired once the scanner has had time to visit it.
   function automatic void m_settle();
      for (int c = 0; c < N_CH; c++) begin
         if (m_arm[c] && int'(cyc - m_dl[c]) >= 0) begin
            m_pend[c] = 1'b1; m_arm[c] = 1'b0;
         end
      end
   endfunction

   // Edge k (k>=1 after reset) compares channel (k-1) mod N_CH.
   function automatic logic [31:0] scan_edge(input int ch, input logic [31:0] min_edge);
      logic [31:0] k;
      k = min_edge;
      while (int'((k - 32'd1) % N_CH) != ch) k = k + 32'd1;
      return k;
   endfunction

   // ---------------- scoreboard ----------------
   typedef struct {
      string       name;
      logic [15:0] exp;
      bit          use_p;
      bit          chk_irq;
      bit          exp_irq;
   } item_t;

   item_t sb_q[$];
   int    errors = 0;
   int    checks = 0;
   logic  rd_issue = 1'b0;
   logic  rd_seen  = 1'b0;

   always @(posedge clk) rd_seen <= rd_issue;

   always @(negedge clk) begin
      item_t       it;
      logic [15:0] act;
      if (rd_seen) begin
         if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_empty: got readdata %h, want a queued expectation", readdata);
         end else begin
            it  = sb_q.pop_front();
            act = it.use_p ? readdata_p : readdata;
            checks++;
            if (act !== it.exp) begin
               errors++;
               $display("FAIL %s: got %h, want %h", it.name, act, it.exp);
            end else begin
               $display("check %s: readdata %h ok", it.name, act);
            end
            if (it.chk_irq) begin
               checks++;
               if (irq !== it.exp_irq) begin
                  errors++;
                  $display("FAIL %s_irq: got %b, want %b", it.name, irq, it.exp_irq);
               end
            end
         end
      end
   end

   // ---------------- bus tasks (called at negedge) ----------------
   task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      m_write(a, d);
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic bus_read(input logic [3:0] a, input string nm, input bit chk_irq);
      item_t it;
      address = a; chipselect = 1'b1; read_n = 1'b0; rd_issue = 1'b1;
      it.name = nm; it.exp = m_read(a); it.use_p = 1'b0;
      it.chk_irq = chk_irq; it.exp_irq = |(m_pend & m_irqen);
      sb_q.push_back(it);
      if (a == 4'd3) m_shadow = cyc[31:16];
      @(negedge clk);
      chipselect = 1'b0; read_n = 1'b1; rd_issue = 1'b0;
   endtask

   // Tick read checked on the slow-prescaler instance.
   task automatic read_p_tick(input string nm);
      item_t it;
      logic [31:0] t;
      address = 4'd3; chipselect = 1'b1; read_n = 1'b0; rd_issue = 1'b1;
      t = cyc / PS_SLOW;
      it.name = nm; it.exp = t[15:0]; it.use_p = 1'b1; it.chk_irq = 1'b0; it.exp_irq = 1'b0;
      sb_q.push_back(it);
      m_shadow = cyc[31:16];
      @(negedge clk);
      chipselect = 1'b0; read_n = 1'b1; rd_issue = 1'b0;
   endtask

   task automatic wait_cyc(input logic [31:0] t);
      if (cyc > t) begin
         checks++; errors++;
         $display("FAIL sched_late: cycle %0d, wanted %0d", cyc, t);
      end else begin
         repeat (int'(t - cyc)) @(negedge clk);
      end
   endtask

   task automatic reset_and_check(input string tag);
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      m_reset();
      wait_cyc(32'd4);
      read_p_tick({tag, "_presc_before"});
      read_p_tick({tag, "_presc_first"});
      for (int a = 0; a < 16; a++) bus_read(4'(a), $sformatf("%s_addr%0d", tag, a), 1'b1);
   endtask

   function automatic logic [31:0] rand_deadline();
      case ($urandom_range(0, 3))
         0:       return cyc - $urandom_range(16, 32'h7FFE0000);
         1:       return cyc + $urandom_range(40, 60);
         2:       return cyc + $urandom_range(32'h00020000, 32'h7FFE0000);
         default: return cyc + $urandom_range(32'h80020000, 32'hFFFF0000);
      endcase
   endfunction

   task automatic arm(input int c, input logic [31:0] dl);
      bus_write(4'(6 + 2 * c), dl[15:0]);
      bus_write(4'(7 + 2 * c), dl[31:16]);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] k;
      logic [31:0] dl;
      int          c;
      m_reset();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      wait_cyc(32'd4);
      read_p_tick("presc_before");
      read_p_tick("presc_first");
      for (int a = 0; a < 16; a++) bus_read(4'(a), $sformatf("rst_addr%0d", a), 1'b1);

      // Channel 2 at 0x100, armed at tick 0x40.
      bus_write(4'd1, 16'h000F);
      wait_cyc(32'h40);
      arm(2, 32'h0000_0100);
      wait_cyc(32'hFD);
      bus_read(4'd0, "ch2_not_early", 1'b1);
      wait_cyc(32'h104);
      m_settle();
      bus_read(4'd0, "ch2_pending", 1'b1);
      bus_read(4'd2, "ch2_armed_clr", 1'b1);
      bus_write(4'd0, 16'h0004);

      // Past deadline across the wrap, then W1C racing a re-expiry.
      dl = cyc - 32'h1000;
      arm(1, dl);
      repeat (8) @(negedge clk);
      m_settle();
      bus_read(4'd0, "ch1_past", 1'b1);
      bus_write(4'd7 + 4'd2 - 4'd2 + 4'd2, dl[31:16]);
      k = scan_edge(1, cyc + 32'd1);
      wait_cyc(k - 32'd1);
      bus_write(4'd0, 16'h0002);
      repeat (8) @(negedge clk);
      m_settle();
      bus_read(4'd0, "ch1_set_wins", 1'b1);
      bus_write(4'd0, 16'h0002);

      // Disarm write on the exact cycle channel 3 expires.
      dl = cyc + 32'd40;
      arm(3, dl);
      k = scan_edge(3, dl + 32'd1);
      wait_cyc(k - 32'd1);
      bus_write(4'd2, 16'h0008);
      repeat (8) @(negedge clk);
      m_settle();
      bus_read(4'd0, "ch3_disarm_wins", 1'b1);
      bus_read(4'd2, "ch3_armed", 1'b1);

      // Re-arm channel 0 on the cycle its old deadline would fire.
      dl = cyc + 32'd30;
      arm(0, dl);
      k = scan_edge(0, dl + 32'd1);
      bus_write(4'd6, 16'h1234);
      wait_cyc(k - 32'd1);
      bus_write(4'd7, 16'h0004);
      repeat (8) @(negedge clk);
      m_settle();
      bus_read(4'd0, "ch0_rearm_pend", 1'b1);
      bus_read(4'd2, "ch0_rearm_armed", 1'b1);
      bus_read(4'd7, "ch0_dl_hi", 1'b0);
      bus_write(4'd2, 16'h0001);

      // Randomized traffic, each op followed by a settle interval.
      for (int n = 0; n < 150; n++) begin
         c = int'($urandom_range(0, N_CH - 1));
         case ($urandom_range(0, 4))
            0: arm(c, rand_deadline());
            1: bus_write(4'd2, 16'($urandom_range(0, 15)));
            2: bus_write(4'd0, 16'($urandom_range(0, 15)));
            3: bus_write(4'd1, 16'($urandom_range(0, 15)));
            default: bus_write(4'(6 + 2 * c), 16'($urandom_range(0, 16'hFFFF)));
         endcase
         repeat (80) @(negedge clk);
         m_settle();
         bus_read(4'd0, $sformatf("rnd%0d_pending", n), 1'b1);
         bus_read(4'd2, $sformatf("rnd%0d_armed", n), 1'b1);
         bus_read(4'd1, $sformatf("rnd%0d_irqen", n), 1'b1);
         bus_read(4'($urandom_range(0, 15)), $sformatf("rnd%0d_any", n), 1'b0);
      end

      // Reset in the middle of activity.
      arm(1, cyc + 32'h30000);
      reset_and_check("midrst");

      // Shadow holds across the 16-bit carry until the next low read.
      wait_cyc(32'h0000_FFFC);
      bus_read(4'd3, "tick_lo_pre_carry", 1'b0);
      wait_cyc(32'h0001_0004);
      bus_read(4'd4, "shadow_held", 1'b0);
      bus_read(4'd3, "tick_lo_post_carry", 1'b0);
      repeat (10) @(negedge clk);
      bus_read(4'd4, "shadow_hi", 1'b0);

      repeat (3) @(negedge clk);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d outstanding reads, want 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: got no completion, want finish before time limit");
      $fatal(1, "watchdog");
   end

endmodule
